// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port round-robin arbiter in front of a single-port data
//               memory. Port 0 serves the EXEC datapath and port 1 serves the
//               program loader / debug port. Only one transaction is in flight
//               at a time. The arbiter is the only driver of the memory
//               address, enable and write-data pins. Read data goes back to
//               the granted port together with a one-cycle valid pulse.
//
// Ports       : clk, rst               clock, asynchronous active-high reset
//               pN_req/we/addr/wdata   requester N (N=0,1) transaction inputs
//               pN_gnt                 1-cycle pulse, request issued to memory
//               pN_rvalid/pN_rdata     1-cycle read response, data held after
//               mem_addr/r_en/w_en     memory control (registered)
//               mem_data_in            memory write data (registered)
//               mem_data_out           memory read data
//               busy                   high whenever the FSM is not idle
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_LEN   = 8,
    parameter int WORD_LEN   = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [ADDR_LEN-1:0] p0_addr,
    input  logic [WORD_LEN-1:0] p0_wdata,
    output logic                p0_gnt,
    output logic                p0_rvalid,
    output logic [WORD_LEN-1:0] p0_rdata,

    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_LEN-1:0] p1_addr,
    input  logic [WORD_LEN-1:0] p1_wdata,
    output logic                p1_gnt,
    output logic                p1_rvalid,
    output logic [WORD_LEN-1:0] p1_rdata,

    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic [WORD_LEN-1:0] mem_data_in,
    input  logic [WORD_LEN-1:0] mem_data_out,

    output logic                busy
);

    // Read-wait counter holds values 0 .. MEM_RD_LAT-1.
    localparam int c_CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MEM_RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RWAIT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_last_gnt;   // port granted most recently
    logic                 r_win_id;     // port owning the transaction in flight
    logic                 r_win_we;     // latched write flag of that transaction
    logic [c_CNT_W-1:0]   r_cnt;

    // ------------------------------------------------------------------------
    // Winner selection, only consumed while idle. A lone requester always
    // wins; on a tie the port that was not granted last time goes first.
    // ------------------------------------------------------------------------
    logic                 w_any_req;
    logic                 w_win_id;
    logic                 w_win_we;
    logic [ADDR_LEN-1:0]  w_win_addr;
    logic [WORD_LEN-1:0]  w_win_wdata;

    always_comb begin
        w_any_req   = p0_req | p1_req;
        w_win_id    = (p0_req && p1_req) ? ~r_last_gnt : p1_req;
        w_win_we    = w_win_id ? p1_we    : p0_we;
        w_win_addr  = w_win_id ? p1_addr  : p0_addr;
        w_win_wdata = w_win_id ? p1_wdata : p0_wdata;
    end

    // ------------------------------------------------------------------------
    // Control FSM. Every output is a register, so each one is loaded on the
    // edge that enters the state in which it must be visible.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_gnt  <= 1'b1;
            r_win_id    <= 1'b0;
            r_win_we    <= 1'b0;
            r_cnt       <= '0;
            p0_gnt      <= 1'b0;
            p0_rvalid   <= 1'b0;
            p0_rdata    <= '0;
            p1_gnt      <= 1'b0;
            p1_rvalid   <= 1'b0;
            p1_rdata    <= '0;
            mem_addr    <= '0;
            mem_r_en    <= 1'b0;
            mem_w_en    <= 1'b0;
            mem_data_in <= '0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // Latch the winning request; later changes on the
                        // request inputs do not affect this transaction.
                        r_win_id    <= w_win_id;
                        r_win_we    <= w_win_we;
                        mem_addr    <= w_win_addr;
                        mem_data_in <= w_win_wdata;
                        mem_w_en    <= w_win_we;
                        mem_r_en    <= ~w_win_we;
                        p0_gnt      <= ~w_win_id;
                        p1_gnt      <= w_win_id;
                        busy        <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    p0_gnt     <= 1'b0;
                    p1_gnt     <= 1'b0;
                    mem_w_en   <= 1'b0;
                    mem_r_en   <= 1'b0;
                    r_last_gnt <= r_win_id;
                    if (r_win_we) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_RWAIT;
                    end
                end

                S_RWAIT: begin
                    // mem_addr is left untouched so the memory sees a stable
                    // address for the whole read latency.
                    if (r_cnt == '0) begin
                        if (r_win_id) begin
                            p1_rdata  <= mem_data_out;
                            p1_rvalid <= 1'b1;
                        end else begin
                            p0_rdata  <= mem_data_out;
                            p0_rvalid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_RESP: begin
                    p0_rvalid <= 1'b0;
                    p1_rvalid <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    p0_gnt    <= 1'b0;
                    p1_gnt    <= 1'b0;
                    p0_rvalid <= 1'b0;
                    p1_rvalid <= 1'b0;
                    mem_w_en  <= 1'b0;
                    mem_r_en  <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
